// File: rtl/alu_pd_switch.sv
// ALU power-domain responder: power-switch state machine with programmable
// ramps, output isolation of the ALU result path, domain reset, power-good,
// sticky isolation-ordering error flag and a saturating OFF-cycle counter.
module alu_pd_switch #(
    parameter int                RAMP_UP_CYCLES = 4,
    parameter int                RAMP_DN_CYCLES = 2,
    parameter int                DATA_W         = 8,
    parameter logic [DATA_W-1:0] CLAMP_VAL      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        iso_ctrl,
    input  logic [3:0]        psw_ctrl,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic              alu_valid_in,
    output logic [DATA_W-1:0] alu_result_out,
    output logic              alu_valid_out,
    output logic              pwr_good,
    output logic [1:0]        domain_state,
    output logic              alu_rst_n,
    output logic              iso_err,
    output logic [15:0]       off_cycles
);

    // state      | meaning
    // ST_ON      | domain powered, isolation follows iso_ctrl
    // ST_RAMP_DN | switch turning off, counting RAMP_DN_CYCLES
    // ST_OFF     | domain unpowered, off_cycles counting
    // ST_RAMP_UP | switch turning on, counting RAMP_UP_CYCLES (full ramp always)
    typedef enum logic [1:0] {
        ST_ON      = 2'd0,
        ST_RAMP_DN = 2'd1,
        ST_OFF     = 2'd2,
        ST_RAMP_UP = 2'd3
    } state_t;

    localparam int RAMP_MAX = (RAMP_UP_CYCLES > RAMP_DN_CYCLES) ? RAMP_UP_CYCLES : RAMP_DN_CYCLES;
    localparam int CNT_W    = (RAMP_MAX > 1) ? $clog2(RAMP_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_UP_LOAD = CNT_W'(RAMP_UP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DN_LOAD = CNT_W'(RAMP_DN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              pwr_good_q, pwr_good_d;
    logic              alu_rst_n_q, alu_rst_n_d;
    logic              iso_err_q, iso_err_d;
    logic [15:0]       off_cycles_q, off_cycles_d;

    logic req_off;
    logic unused_ctrl_bits;

    assign req_off          = psw_ctrl[1];
    assign unused_ctrl_bits = ^{iso_ctrl[3:2], psw_ctrl[3:2], psw_ctrl[0]};

    // Next-state, ramp counter, isolation and status computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        iso_err_d    = iso_err_q;
        off_cycles_d = off_cycles_q;

        unique case (state_q)
            ST_ON: begin
                if (req_off) begin
                    state_d = ST_RAMP_DN;
                    cnt_d   = CNT_DN_LOAD;
                    // Power-down must only start with both data and valid clamped.
                    if (iso_ctrl[1:0] != 2'b11) begin
                        iso_err_d = 1'b1;
                    end
                end
            end
            ST_RAMP_DN: begin
                if (!req_off) begin
                    state_d = ST_RAMP_UP;
                    cnt_d   = CNT_UP_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_OFF: begin
                if (!req_off) begin
                    state_d = ST_RAMP_UP;
                    cnt_d   = CNT_UP_LOAD;
                end
                if (off_cycles_q != 16'hFFFF) begin
                    off_cycles_d = off_cycles_q + 16'd1;
                end
            end
            ST_RAMP_UP: begin
                if (req_off) begin
                    state_d = ST_RAMP_DN;
                    cnt_d   = CNT_DN_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_ON;
                cnt_d   = '0;
            end
        endcase

        // Clamp uses the current registered state, so the first ON cycle is still clamped.
        result_d    = (iso_ctrl[0] || (state_q != ST_ON)) ? CLAMP_VAL : alu_result_in;
        valid_d     = (iso_ctrl[1] || (state_q != ST_ON)) ? 1'b0 : alu_valid_in;
        pwr_good_d  = (state_d == ST_ON);
        alu_rst_n_d = (state_d == ST_ON);
    end

    // Single state/output register bank with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ON;
            cnt_q        <= '0;
            result_q     <= CLAMP_VAL;
            valid_q      <= 1'b0;
            pwr_good_q   <= 1'b1;
            alu_rst_n_q  <= 1'b1;
            iso_err_q    <= 1'b0;
            off_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            pwr_good_q   <= pwr_good_d;
            alu_rst_n_q  <= alu_rst_n_d;
            iso_err_q    <= iso_err_d;
            off_cycles_q <= off_cycles_d;
        end
    end

    assign alu_result_out = result_q;
    assign alu_valid_out  = valid_q;
    assign pwr_good       = pwr_good_q;
    assign domain_state   = state_q;
    assign alu_rst_n      = alu_rst_n_q;
    assign iso_err        = iso_err_q;
    assign off_cycles     = off_cycles_q;

endmodule

// File: tb/tb_alu_pd_switch.sv
// Bench for alu_pd_switch: directed PMU sequences, a cycle-level reference
// model checked every cycle, and literal checkpoints at key moments.
module tb_alu_pd_switch;

    localparam int UP_N = 4;
    localparam int DN_N = 2;

    localparam int P_ON      = 0;
    localparam int P_RAMP_DN = 1;
    localparam int P_OFF     = 2;
    localparam int P_RAMP_UP = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  iso_ctrl;
    logic [3:0]  psw_ctrl;
    logic [7:0]  alu_result_in;
    logic        alu_valid_in;
    logic [7:0]  alu_result_out;
    logic        alu_valid_out;
    logic        pwr_good;
    logic [1:0]  domain_state;
    logic        alu_rst_n;
    logic        iso_err;
    logic [15:0] off_cycles;

    int total;
    int bad;
    bit chk_en;

    // Reference model: phase plus cycles left in the current ramp.
    int          m_phase;
    int          m_left;
    logic [7:0]  m_res;
    logic        m_val;
    bit          m_err;
    int          m_off;

    alu_pd_switch #(
        .RAMP_UP_CYCLES(UP_N),
        .RAMP_DN_CYCLES(DN_N),
        .DATA_W(8),
        .CLAMP_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .iso_ctrl(iso_ctrl),
        .psw_ctrl(psw_ctrl),
        .alu_result_in(alu_result_in),
        .alu_valid_in(alu_valid_in),
        .alu_result_out(alu_result_out),
        .alu_valid_out(alu_valid_out),
        .pwr_good(pwr_good),
        .domain_state(domain_state),
        .alu_rst_n(alu_rst_n),
        .iso_err(iso_err),
        .off_cycles(off_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model update on each rising edge from the inputs the DUT also samples.
    always @(posedge clk or negedge rst_n) begin
        int  nphase;
        int  nleft;
        bit  req;
        bit  powered;
        if (!rst_n) begin
            m_phase <= P_ON;
            m_left  <= 0;
            m_res   <= 8'h00;
            m_val   <= 1'b0;
            m_err   <= 1'b0;
            m_off   <= 0;
        end else begin
            req     = psw_ctrl[1];
            powered = (m_phase == P_ON);
            nphase  = m_phase;
            nleft   = m_left;
            if (m_phase == P_ON) begin
                if (req) begin
                    nphase = P_RAMP_DN;
                    nleft  = DN_N;
                end
            end else if (m_phase == P_OFF) begin
                if (!req) begin
                    nphase = P_RAMP_UP;
                    nleft  = UP_N;
                end
            end else begin
                // In a ramp: a change of request restarts the opposite ramp in full.
                if (m_phase == P_RAMP_DN && !req) begin
                    nphase = P_RAMP_UP;
                    nleft  = UP_N;
                end else if (m_phase == P_RAMP_UP && req) begin
                    nphase = P_RAMP_DN;
                    nleft  = DN_N;
                end else if (m_left == 1) begin
                    nphase = (m_phase == P_RAMP_DN) ? P_OFF : P_ON;
                    nleft  = 0;
                end else begin
                    nleft = m_left - 1;
                end
            end
            m_phase <= nphase;
            m_left  <= nleft;
            m_res   <= (powered && !iso_ctrl[0]) ? alu_result_in : 8'h00;
            m_val   <= (powered && !iso_ctrl[1]) ? alu_valid_in : 1'b0;
            if (powered && req && (iso_ctrl[1:0] != 2'b11)) m_err <= 1'b1;
            if (m_phase == P_OFF && m_off < 65535) m_off <= m_off + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_result",   32'(alu_result_out), 32'(m_res));
            chk("cyc_valid",    32'(alu_valid_out),  32'(m_val));
            chk("cyc_state",    32'(domain_state),   32'(m_phase));
            chk("cyc_pwr_good", 32'(pwr_good),       32'(m_phase == P_ON));
            chk("cyc_alu_rst",  32'(alu_rst_n),      32'(m_phase == P_ON));
            chk("cyc_iso_err",  32'(iso_err),        32'(m_err));
            chk("cyc_off",      32'(off_cycles),     32'(m_off));
        end
    end

    // Legal PMU power-down: valid isolation one cycle ahead, then data isolation with req_off.
    task automatic legal_down();
        iso_ctrl = 4'b0010;
        tick();
        iso_ctrl = 4'b0011;
        psw_ctrl = 4'b0010;
        repeat (DN_N + 1) tick();
    endtask

    task automatic legal_up();
        psw_ctrl = 4'b0000;
        iso_ctrl = 4'b0010;
        repeat (UP_N + 1) tick();
        iso_ctrl = 4'b0000;
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        chk_en        = 1'b0;
        rst_n         = 1'b0;
        iso_ctrl      = 4'b0000;
        psw_ctrl      = 4'b0000;
        alu_result_in = 8'hA5;
        alu_valid_in  = 1'b1;
        #1 chk_en = 1'b1;

        // Reset, then pass-through from the first edge.
        tick();
        chk("rst_result", 32'(alu_result_out), 32'h00);
        chk("rst_valid",  32'(alu_valid_out),  32'h0);
        chk("rst_state",  32'(domain_state),   32'd0);
        chk("rst_pgood",  32'(pwr_good),       32'd1);
        rst_n = 1'b1;
        tick();
        chk("pass_result", 32'(alu_result_out), 32'hA5);
        chk("pass_valid",  32'(alu_valid_out),  32'h1);
        alu_result_in = 8'h3C;
        tick();
        chk("pass_result2", 32'(alu_result_out), 32'h3C);

        // Nominal power-down.
        iso_ctrl = 4'b0010;
        tick();
        chk("iso_valid_clamp", 32'(alu_valid_out), 32'h0);
        chk("iso_data_open",   32'(alu_result_out), 32'h3C);
        iso_ctrl = 4'b0011;
        psw_ctrl = 4'b0010;
        tick();
        chk("dn1_state",  32'(domain_state), 32'd1);
        chk("dn1_alurst", 32'(alu_rst_n),    32'd0);
        chk("dn1_pgood",  32'(pwr_good),     32'd0);
        chk("dn1_err",    32'(iso_err),      32'd0);
        tick();
        chk("dn2_state", 32'(domain_state), 32'd1);
        tick();
        chk("off_state", 32'(domain_state), 32'd2);
        chk("off_cnt0",  32'(off_cycles),   32'd0);
        repeat (10) tick();
        chk("off_cnt10", 32'(off_cycles),   32'd10);

        // Power-up: exactly UP_N ramp cycles, first ON cycle still clamped.
        psw_ctrl = 4'b0000;
        iso_ctrl = 4'b0010;
        tick();
        chk("up1_state", 32'(domain_state), 32'd3);
        tick();
        iso_ctrl = 4'b0000;
        tick();
        tick();
        chk("up4_state", 32'(domain_state), 32'd3);
        chk("up4_pgood", 32'(pwr_good),     32'd0);
        tick();
        chk("on_state",    32'(domain_state),   32'd0);
        chk("on_pgood",    32'(pwr_good),       32'd1);
        chk("on_alurst",   32'(alu_rst_n),      32'd1);
        chk("on_clamped",  32'(alu_result_out), 32'h00);
        chk("on_vclamped", 32'(alu_valid_out),  32'h0);
        tick();
        chk("on_pass",  32'(alu_result_out), 32'h3C);
        chk("on_vpass", 32'(alu_valid_out),  32'h1);
        chk("up_err",   32'(iso_err),        32'd0);

        // Illegal power-down without isolation: sticky error.
        psw_ctrl = 4'b0010;
        iso_ctrl = 4'b0000;
        tick();
        chk("bad_err",   32'(iso_err),      32'd1);
        chk("bad_state", 32'(domain_state), 32'd1);
        tick();
        tick();
        legal_up();
        legal_down();
        chk("sticky_state", 32'(domain_state), 32'd2);
        legal_up();
        chk("sticky_err", 32'(iso_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("err_clear", 32'(iso_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Abort a power-down after one ramp cycle: full power-up ramp.
        iso_ctrl = 4'b0010;
        tick();
        iso_ctrl = 4'b0011;
        psw_ctrl = 4'b0010;
        tick();
        chk("ab_dn", 32'(domain_state), 32'd1);
        psw_ctrl = 4'b0000;
        repeat (UP_N) begin
            tick();
            chk("ab_up", 32'(domain_state), 32'd3);
        end
        tick();
        chk("ab_on", 32'(domain_state), 32'd0);

        // Abort again, then re-request off in the second RAMP_UP cycle.
        psw_ctrl = 4'b0010;
        tick();
        psw_ctrl = 4'b0000;
        tick();
        tick();
        chk("re_up2", 32'(domain_state), 32'd3);
        psw_ctrl = 4'b0010;
        tick();
        chk("re_dn1", 32'(domain_state), 32'd1);
        tick();
        chk("re_dn2", 32'(domain_state), 32'd1);
        tick();
        chk("re_off", 32'(domain_state), 32'd2);

        // Long OFF: counter saturates.
        repeat (70000) tick();
        chk("off_sat", 32'(off_cycles), 32'hFFFF);
        tick();
        chk("off_nowrap", 32'(off_cycles), 32'hFFFF);

        // Asynchronous reset mid-ramp-up.
        psw_ctrl = 4'b0000;
        tick();
        tick();
        chk("mid_up", 32'(domain_state), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state",  32'(domain_state), 32'd0);
        chk("arst_pgood",  32'(pwr_good),     32'd1);
        chk("arst_alurst", 32'(alu_rst_n),    32'd1);
        chk("arst_off",    32'(off_cycles),   32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_stay_on", 32'(domain_state), 32'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_pd_switch.md
# alu_pd_switch

Power-domain responder for the ALU low-power scheme: the receiving end of the PMU's `iso_ctrl`/`psw_ctrl` sequence. It models the ALU domain's power switch as a four-state machine with programmable ramp times. It applies output isolation (clamping) to the ALU result path and drives the domain-local reset. It also reports power-good, flags isolation-ordering violations on power-down, and counts cycles spent powered off. It sits between the PMU and the ALU datapath outputs.

## Interface
- `RAMP_UP_CYCLES`, default 4: cycles spent in RAMP_UP; legal range ≥1.
- `RAMP_DN_CYCLES`, default 2: cycles spent in RAMP_DN; legal range ≥1.
- `DATA_W`, default 8: ALU result width.
- `CLAMP_VAL`, default 0: value driven on `alu_result_out` while isolated.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `iso_ctrl`  in  4  from PMU. Bit 0 isolates data; bit 1 isolates valid. Bits 3:2 are ignored.
- `psw_ctrl`  in  4  from PMU. Bit 1 = 1 requests domain off. Bits 3:2 and 0 are ignored.
- `alu_result_in`  in  DATA_W  raw ALU result.
- `alu_valid_in`  in  1  raw ALU valid.
- `alu_result_out`  out  DATA_W  isolated result, registered.
- `alu_valid_out`  out  1  isolated valid, registered.
- `pwr_good`  out  1  1 only in state ON.
- `domain_state`  out  2  encoding: ON=0, RAMP_DN=1, OFF=2, RAMP_UP=3.
- `alu_rst_n`  out  1  domain reset to the ALU; 0 in every state except ON.
- `iso_err`  out  1  sticky power-down ordering violation.
- `off_cycles`  out  16  saturating count of cycles spent in OFF.

## Operation
- Reset values: state ON, ramp counter 0, `pwr_good`=1, `alu_rst_n`=1, `alu_result_out`=`CLAMP_VAL`, `alu_valid_out`=0, `iso_err`=0, `off_cycles`=0.
- `req_off` denotes `psw_ctrl[1]`. It is sampled every rising edge.
- FSM transitions:
  - ON, `req_off`=1: go to RAMP_DN; load counter with `RAMP_DN_CYCLES-1`.
  - RAMP_DN, `req_off`=1 and counter=0: go to OFF.
  - RAMP_DN, `req_off`=1 and counter>0: decrement the counter.
  - RAMP_DN, `req_off`=0: abort to RAMP_UP; load counter with `RAMP_UP_CYCLES-1`. The full ramp always applies; there is no partial credit.
  - OFF, `req_off`=0: go to RAMP_UP; load counter with `RAMP_UP_CYCLES-1`.
  - RAMP_UP, `req_off`=1: go to RAMP_DN; load counter with `RAMP_DN_CYCLES-1`.
  - RAMP_UP, counter=0: go to ON.
  - RAMP_UP, otherwise: decrement the counter.
- Isolation, updated every edge:
  - `alu_result_out` <= `CLAMP_VAL` if `iso_ctrl[0]`=1 or state≠ON; otherwise `alu_result_in`.
  - `alu_valid_out` <= 0 if `iso_ctrl[1]`=1 or state≠ON; otherwise `alu_valid_in`.
  - The block therefore self-isolates whenever it is not ON, regardless of the `iso_ctrl` bits.
- `pwr_good`, `alu_rst_n` and `domain_state` are registered alongside the state; they are the state register or decodes of it.
- `iso_err` is set on the ON→RAMP_DN edge if `iso_ctrl[1:0]`≠2'b11 at that sample. It is cleared only by `rst_n`.
  - Releasing isolation during RAMP_UP is legal and never flags.
- `off_cycles` increments once per cycle while state=OFF. It saturates at 16'hFFFF and never wraps. It is cleared only by reset.

## Timing
- Power-down: with `req_off` rising at edge t, state is RAMP_DN for `RAMP_DN_CYCLES` cycles (t+1 … t+N). State is OFF from t+N+1.
- Power-up: with `req_off` falling at edge t in OFF, state is RAMP_UP for `RAMP_UP_CYCLES` cycles. `pwr_good` and `alu_rst_n` go to 1 on the same edge that enters ON.
- Isolation outputs have 1-cycle latency from `iso_ctrl`/`alu_*_in`.
- The state-based clamp uses the current registered state. The first ON cycle therefore still outputs clamped values, and pass-through begins one cycle later.
- Asynchronous reset mid-ramp: the block returns immediately to reset values; the ramp is not resumed.
- PMU nominal sequence (`iso_ctrl[1]` one cycle ahead, then `iso_ctrl[0]` and `psw_ctrl[1]` together) produces `iso_err`=0.

## Test plan
- Reset with `alu_valid_in`=1 and `alu_result_in`=8'hA5 → outputs are 8'h00/0 in the first cycle and 8'hA5/1 from the next edge. State is ON and `pwr_good`=1.
- Set `iso_ctrl`=4'b0010, then one cycle later `iso_ctrl`=4'b0011 together with `psw_ctrl`=4'b0010 (defaults) → RAMP_DN for 2 cycles, then OFF. `alu_rst_n`=0 and `iso_err`=0. `off_cycles` reads 10 after 10 OFF cycles.
- From OFF, drop `psw_ctrl[1]` and `iso_ctrl[0]` together → RAMP_UP for exactly 4 cycles, then ON. Outputs stay clamped until one cycle after entering ON.
- Assert `psw_ctrl[1]` while `iso_ctrl`=0 → `iso_err`=1 and stays 1 through later legal sequences until `rst_n` pulses.
- Drop `req_off` after 1 cycle of RAMP_DN → abort to RAMP_UP with the full 4 cycles. Re-assert `req_off` in RAMP_UP cycle 2 → RAMP_DN for 2 cycles, then OFF.
- Hold OFF for 70000 cycles → `off_cycles`=16'hFFFF with no wrap. Assert `rst_n`=0 during RAMP_UP → immediate ON, `pwr_good`=1, `off_cycles`=0.
